// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input, parallel word output and status bundle for sipo_deserializer
interface sipo_deserializer_if #(
    parameter int WIDTH = 10
);
    logic             si;
    logic             si_valid;
    logic             sync;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             busy;
    logic             overrun;

    // master drives the serial stream and consumes words; slave is the deserializer
    modport master (
        output si, si_valid, sync, po_ready,
        input  po, po_valid, busy, overrun
    );

    modport slave (
        input  si, si_valid, sync, po_ready,
        output po, po_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - MSB-first serial-in parallel-out deserializer with valid/ready holding register
module sipo_deserializer #(
    parameter int WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deserializer_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] po_q;
    logic             po_valid_q;
    logic             overrun_q;

    logic             last_bit;
    logic             complete;
    logic             take;
    logic             slot_free;
    logic [WIDTH-1:0] word;

    // explicit terminal compare: WIDTH need not be a power of two
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign complete  = bus.si_valid && !bus.sync && last_bit;
    assign take      = po_valid_q && bus.po_ready;
    assign slot_free = !po_valid_q || bus.po_ready;
    assign word      = {sr[WIDTH-2:0], bus.si};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bus.sync) begin
            // a bit arriving with SYNC is the MSB of the next word
            if (bus.si_valid) begin
                sr  <= {{(WIDTH-1){1'b0}}, bus.si};
                cnt <= CW'(1);
            end else begin
                sr  <= '0;
                cnt <= '0;
            end
        end else if (bus.si_valid) begin
            sr  <= word;
            cnt <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= complete && !slot_free;
            if (complete && slot_free) begin
                po_q       <= word;
                po_valid_q <= 1'b1;
            end else if (take) begin
                po_valid_q <= 1'b0;
            end
        end
    end

    assign bus.po       = po_q;
    assign bus.po_valid = po_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = (cnt != '0);
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sipo_deserializer_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.si       = b;
        bus.si_valid = 1'b1;
        step();
        bus.si_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    logic [W-1:0] bits_2ce;
    logic [W-1:0] piso;
    logic         saw_valid;
    logic         saw_overrun;

    initial begin
        bus.si       = 1'b0;
        bus.si_valid = 1'b0;
        bus.sync     = 1'b0;
        bus.po_ready = 1'b0;
        bits_2ce     = 10'b1011001110;

        // reset state while reset held
        #12;
        chk("rst_po", 32'(bus.po), 32'h0);
        chk("rst_po_valid", 32'(bus.po_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // test 1: async reset mid-word with a held word
        send_word(10'h3A5);
        chk("t1_pre_po", 32'(bus.po), 32'h3A5);
        chk("t1_pre_valid", 32'(bus.po_valid), 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("t1_pre_busy", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_po", 32'(bus.po), 32'h0);
        chk("t1_po_valid", 32'(bus.po_valid), 32'h0);
        chk("t1_busy", 32'(bus.busy), 32'h0);
        chk("t1_overrun", 32'(bus.overrun), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // test 2: basic word with consumer always ready
        bus.po_ready = 1'b1;
        for (int i = W - 1; i >= 1; i--) send_bit(bits_2ce[i]);
        chk("t2_no_early_valid", 32'(bus.po_valid), 32'h0);
        send_bit(bits_2ce[0]);
        chk("t2_po", 32'(bus.po), 32'h2CE);
        chk("t2_po_valid", 32'(bus.po_valid), 32'h1);
        chk("t2_busy", 32'(bus.busy), 32'h0);
        step();
        chk("t2_taken", 32'(bus.po_valid), 32'h0);
        chk("t2_po_hold", 32'(bus.po), 32'h2CE);

        // test 3: gapped input
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(bits_2ce[i]);
            if (i != 0) begin
                step();
                chk("t3_busy_gap", 32'(bus.busy), 32'h1);
                chk("t3_no_valid", 32'(bus.po_valid), 32'h0);
            end
        end
        chk("t3_po", 32'(bus.po), 32'h2CE);
        chk("t3_po_valid", 32'(bus.po_valid), 32'h1);
        step();
        chk("t3_taken", 32'(bus.po_valid), 32'h0);

        // test 4: backpressure and overrun
        bus.po_ready = 1'b0;
        send_word(10'h3FF);
        chk("t4_first_po", 32'(bus.po), 32'h3FF);
        chk("t4_first_overrun", 32'(bus.overrun), 32'h0);
        send_word(10'h001);
        chk("t4_overrun", 32'(bus.overrun), 32'h1);
        chk("t4_po_kept", 32'(bus.po), 32'h3FF);
        chk("t4_valid_kept", 32'(bus.po_valid), 32'h1);
        step();
        chk("t4_overrun_pulse", 32'(bus.overrun), 32'h0);
        bus.po_ready = 1'b1;
        step();
        chk("t4_drained", 32'(bus.po_valid), 32'h0);

        // test 5: SYNC realignment
        saw_valid   = 1'b0;
        saw_overrun = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            saw_valid   |= bus.po_valid;
            saw_overrun |= bus.overrun;
        end
        bus.sync = 1'b1;
        send_bit(1'b1);
        bus.sync = 1'b0;
        chk("t5_sync_busy", 32'(bus.busy), 32'h1);
        saw_valid |= bus.po_valid;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            saw_valid   |= bus.po_valid;
            saw_overrun |= bus.overrun;
        end
        chk("t5_no_early_word", 32'(saw_valid), 32'h0);
        send_bit(1'b1);
        saw_overrun |= bus.overrun;
        chk("t5_po", 32'(bus.po), 32'h201);
        chk("t5_po_valid", 32'(bus.po_valid), 32'h1);
        chk("t5_no_overrun", 32'(saw_overrun), 32'h0);
        step();
        chk("t5_taken", 32'(bus.po_valid), 32'h0);

        // test 6: loopback from a PISO model, partial junk before SYNC
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        piso = 10'h155;
        step();
        for (int i = 0; i < W; i++) begin
            bus.sync = (i == 0);
            send_bit(piso[W-1]);
            piso = {piso[W-2:0], 1'b0};
        end
        bus.sync = 1'b0;
        chk("t6_po", 32'(bus.po), 32'h155);
        chk("t6_po_valid", 32'(bus.po_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
